// File: rtl/serial_sat.sv
// Bit-serial saturating limiter for an I2S stereo stream: captures each channel slot,
// limits the signed word to W_OUT bits and re-emits it sign-extended in the same slot one frame later.
module serial_sat #(
    parameter int W_SLOT = 32,
    parameter int W_OUT  = 16
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_bclk,
    input  logic i_lrclk,
    input  logic i_in,
    input  logic i_clr,
    output logic o_out,
    output logic o_clip_l,
    output logic o_clip_r,
    output logic o_frame_err
);

    localparam int CW = $clog2(W_SLOT + 2);
    localparam logic [CW-1:0] CNT_MAX  = CW'(W_SLOT + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(W_SLOT);
    localparam logic [W_SLOT-1:0] SAT_MAX = {{(W_SLOT-W_OUT+1){1'b0}}, {(W_OUT-1){1'b1}}};
    localparam logic [W_SLOT-1:0] SAT_MIN = {{(W_SLOT-W_OUT+1){1'b1}}, {(W_OUT-1){1'b0}}};

    typedef enum logic {ST_SYNC = 1'b0, ST_RUN = 1'b1} state_t;

    // Returns {clip, limited word}; the limited word is already sign-extended to W_SLOT.
    function automatic logic [W_SLOT:0] sat_word(input logic [W_SLOT-1:0] v);
        logic [W_SLOT:0] res;
        if ($signed(v) > $signed(SAT_MAX)) begin
            res = {1'b1, SAT_MAX};
        end else if ($signed(v) < $signed(SAT_MIN)) begin
            res = {1'b1, SAT_MIN};
        end else begin
            res = {1'b0, v};
        end
        return res;
    endfunction

    state_t            r_state, w_state_nxt;
    logic              r_bclk_d, r_lr;
    logic [W_SLOT-1:0] r_cap, r_tx, r_hold_l, r_hold_r;
    logic [CW-1:0]     r_cnt;
    logic              r_out, r_clip_l, r_clip_r, r_frame_err;

    logic              w_rise, w_fall, w_bound;
    logic              w_write, w_err, w_load;
    logic [W_SLOT-1:0] w_cap_nxt;
    logic [CW-1:0]     w_cnt_inc;
    logic [W_SLOT:0]   w_sat;

    assign w_rise    = i_bclk & ~r_bclk_d;
    assign w_fall    = ~i_bclk & r_bclk_d;
    assign w_bound   = w_rise & (i_lrclk ^ r_lr);
    // The boundary bit is the LSB of the ending slot, so it is part of the word being closed.
    assign w_cap_nxt = {r_cap[W_SLOT-2:0], i_in};
    assign w_cnt_inc = (r_cnt == CNT_MAX) ? CNT_MAX : r_cnt + CW'(1);
    assign w_sat     = sat_word(w_cap_nxt);

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_SYNC;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and per-boundary write/error/load decisions.
    always_comb begin
        w_state_nxt = r_state;
        w_write     = 1'b0;
        w_err       = 1'b0;
        w_load      = 1'b0;
        case (r_state)
            ST_SYNC: begin
                if (w_bound) begin
                    w_state_nxt = ST_RUN;
                    w_load      = 1'b1;
                end else begin
                    w_state_nxt = ST_SYNC;
                end
            end
            ST_RUN: begin
                if (w_bound) begin
                    w_load = 1'b1;
                    if (w_cnt_inc == CNT_FULL) begin
                        w_write = 1'b1;
                    end else begin
                        w_err = 1'b1;
                    end
                end else begin
                    w_load = 1'b0;
                end
            end
            default: begin
                w_state_nxt = ST_SYNC;
            end
        endcase
    end

    // Bit-clock edge detect, lrclk sampling, capture shift and bit counter.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_bclk_d <= 1'b0;
            r_lr     <= 1'b0;
            r_cap    <= '0;
            r_cnt    <= '0;
        end else begin
            r_bclk_d <= i_bclk;
            if (w_rise) begin
                r_lr <= i_lrclk;
            end
            if (w_rise && (r_state == ST_RUN)) begin
                r_cap <= w_cap_nxt;
            end
            if (w_bound) begin
                r_cnt <= '0;
            end else if (w_rise && (r_state == ST_RUN)) begin
                r_cnt <= w_cnt_inc;
            end
        end
    end

    // Per-channel hold registers; the ending channel is the previously sampled lrclk.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_hold_l <= '0;
            r_hold_r <= '0;
        end else if (w_write) begin
            if (r_lr) begin
                r_hold_r <= w_sat[W_SLOT-1:0];
            end else begin
                r_hold_l <= w_sat[W_SLOT-1:0];
            end
        end
    end

    // Transmit shifter: load the new channel at a boundary, emit MSB-first on bclk falls.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tx  <= '0;
            r_out <= 1'b0;
        end else if (w_load) begin
            r_tx <= i_lrclk ? r_hold_r : r_hold_l;
        end else if (w_fall) begin
            r_out <= r_tx[W_SLOT-1];
            r_tx  <= {r_tx[W_SLOT-2:0], 1'b0};
        end
    end

    // Sticky flags; a set in the same cycle as clr takes priority.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_clip_l    <= 1'b0;
            r_clip_r    <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_clip_l    <= (w_write & w_sat[W_SLOT] & ~r_lr) | (r_clip_l & ~i_clr);
            r_clip_r    <= (w_write & w_sat[W_SLOT] & r_lr) | (r_clip_r & ~i_clr);
            r_frame_err <= w_err | (r_frame_err & ~i_clr);
        end
    end

    assign o_out       = r_out;
    assign o_clip_l    = r_clip_l;
    assign o_clip_r    = r_clip_r;
    assign o_frame_err = r_frame_err;

endmodule

// File: doc/serial_sat.md
# serial_sat

Bit-serial saturating limiter for the I2S-framed audio path. It deserializes each channel slot of a 2×`w_slot`-bit stereo frame and saturates the signed word to `w_out` bits. The result is re-emitted sign-extended to `w_slot` bits in the same channel slot of the next frame. It sits between the `shift` stage and the `mixer` stage, sharing their `bclk`/`lrclk`, so that accumulated gain never wraps before mixing.

## Interface
- `w_slot`, 32, bits per channel slot (≥ `w_out`+1, ≤ 63)
- `w_out`, 16, signed width the value is limited to (≥ 2)

- `clk` in 1: system clock; all state clocked on rising edge
- `rst` in 1: one clock; reset is asynchronous and active-low
- `bclk` in 1: bit clock, level signal in `clk` domain, period ≥ 4 `clk`
- `lrclk` in 1: word select, 0 = left, 1 = right; changes on `bclk` falling edge
- `in` in 1: serial data, standard I2S, MSB first, offset one `bclk` after `lrclk` change
- `clr` in 1: synchronous clear of sticky flags
- `out` out 1: serial limited data, same framing as `in`
- `clip_l` out 1: sticky, a left word was saturated
- `clip_r` out 1: sticky, a right word was saturated
- `frame_err` out 1: sticky, a slot had ≠ `w_slot` bits

## Operation
- Edge detect: `bclk_d` register. `rise` = `bclk & ~bclk_d`, `fall` = `~bclk & bclk_d`.
- On `rise`: sample `in` and `lrclk`. A boundary is a sampled `lrclk` ≠ the previous sampled `lrclk`. The `in` bit at a boundary is the LSB of the ending slot.
- States: SYNC (after reset) and RUN.
  - SYNC: bits are ignored. At the first boundary, go to RUN and clear the bit counter. Nothing is written and no error is raised.
  - RUN: each `rise` shifts `in` into capture register `cap` (left shift) and increments `cnt`. `cnt` saturates at `w_slot`+1.
- At a boundary in RUN, the ending channel `c` is the previous sampled `lrclk`:
  - If the count including the boundary bit = `w_slot`: saturate `cap` and write it to `hold[c]`.
  - Otherwise: `hold[c]` is unchanged and `frame_err` is set.
  - Then `cnt` is cleared.
- Saturation, with `cap` as signed `w_slot`:
  - If `cap` > 2^(`w_out`−1)−1, result = max and the channel clip flag is set.
  - If `cap` < −2^(`w_out`−1), result = min and the channel clip flag is set.
  - Otherwise the value passes unchanged.
  - The result is stored sign-extended to `w_slot`.
- Transmit, at every boundary (SYNC included once RUN is entered, i.e. from the same edge):
  - `tx` is loaded with `hold[new]`, where `new` is the current sampled `lrclk`.
  - `hold[c]` is written in the same edge, and that write completes before any later load of `hold[c]`.
  - On each `fall`, `out` ← `tx` MSB and `tx` shifts left with zero fill. After `w_slot` bits, `out` = 0 until the next load.
- Latency: a word captured in slot X of frame n appears on `out` in slot X of frame n+1, with `out` bit k aligned to `in` bit k.
- Flags: set by events, cleared by `clr`. If a set and `clr` occur in the same cycle, the set wins.

## Timing
- Reset values: `out`=0, `clip_l`=`clip_r`=`frame_err`=0, `hold[*]`=0, `cap`=0, `cnt`=0, `tx`=0, state=SYNC, `bclk_d`=0, sampled `lrclk`=0.
- Asynchronous assertion drives the outputs to reset values immediately. Deassertion is taken on the next `clk` rise.
- Reset mid-frame: any partial capture is lost and the block resynchronises through SYNC. `out` stays 0 until the first full slot has been captured and transmitted.
- `out` updates one `clk` after the `clk` cycle in which `fall` is detected. It is stable at every `bclk` rising edge.
- Flags update one `clk` after the boundary `rise` cycle.
- `hold`/`tx` conflict: a load and a write of the same channel can't coincide, because the write target is the previous channel and the load target is the new one.

## Test plan
- Reset, then send frames L=0x00001234, R=0xFFFFFF00 repeatedly -> `out` slots in the next frame carry L=0x00001234, R=0xFFFFFF00, with no flags set.
- Send L=0x00012345, R=0x80000000 -> next frame has L=0x00007FFF, R=0xFFFF8000, with `clip_l`=`clip_r`=1. Pulse `clr` -> both flags go to 0.
- Boundary values: L=0x00007FFF and R=0xFFFF8000 pass with no clip. L=0x00008000 gives 0x00007FFF with `clip_l`=1. R=0xFFFF7FFF gives 0xFFFF8000 with `clip_r`=1.
- Left slot of 31 bits after a valid L=0x00000100 -> `frame_err`=1, and the next left output is still 0x00000100.
- Start the stream mid-slot after reset -> the first partial slot is discarded with no `frame_err`. `out`=0 through the first full frame, and the data appears one frame later.
- Assert `rst` mid-slot -> `out` and all flags go to 0 within the same `clk` cycle. After release, output resumes correctly after two boundaries plus one frame.
